multi_timer: RTL

- Parametrised successor to the single-channel PWM_Timer timer: N_CH independent timer channels sharing one clock and one programmable prescaler.
- Each channel has its own counter, period, one-shot/continuous mode, one-cycle expiry pulse, sticky maskable interrupt flag and missed-interrupt (overflow) flag.
- Sits between the register file (ctrl/period/prescale fields) and the o_pwm/interrupt outputs, replacing the timer + main_counter pair when in timer mode.

---
 rtl/multi_timer_pkg.sv | 15 +
 rtl/multi_timer_if.sv | 44 ++++
 rtl/multi_timer_channel.sv | 94 +++++++++
 rtl/multi_timer.sv | 66 ++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer.
//   ch_state_t   : per-channel FSM state (IDLE, RUN, DONE)
//   MODE_*       : ch_mode encoding (one-shot / continuous)
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/multi_timer_if.sv
// Register-file side bundle of the multi-channel timer.
//   master : register file / bench (drives configuration, reads status)
//   slave  : multi_timer (reads configuration, drives status)
// Signals:
//   prescale  tick every prescale+1 clocks
//   ch_en     per-channel enable (level)
//   ch_mode   per-channel mode, 0 = one-shot, 1 = continuous
//   period    channel i uses period[i*WIDTH +: WIDTH]
//   irq_mask  1 = channel flag drives irq
//   irq_clr   single-cycle write-1-to-clear of irq_flag/irq_ovf
//   timer     one-cycle expiry pulse per channel
//   irq_flag  sticky expiry flag
//   irq_ovf   sticky missed-interrupt flag
//   irq       OR over (irq_flag & irq_mask)
//   cnt_dbg   current channel counters
interface multi_timer_if #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);

  logic [PRESC_W-1:0]    prescale;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       ch_mode;
  logic [N_CH*WIDTH-1:0] period;
  logic [N_CH-1:0]       irq_mask;
  logic [N_CH-1:0]       irq_clr;
  logic [N_CH-1:0]       timer;
  logic [N_CH-1:0]       irq_flag;
  logic [N_CH-1:0]       irq_ovf;
  logic                  irq;
  logic [N_CH*WIDTH-1:0] cnt_dbg;

  modport master (
    output prescale, ch_en, ch_mode, period, irq_mask, irq_clr,
    input  timer, irq_flag, irq_ovf, irq, cnt_dbg
  );

  modport slave (
    input  prescale, ch_en, ch_mode, period, irq_mask, irq_clr,
    output timer, irq_flag, irq_ovf, irq, cnt_dbg
  );

endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, up-counter, expiry pulse and
// sticky interrupt / missed-interrupt flags.
// Ports:
//   chosen_clk, rst_n  clock, async active-low reset
//   tick               shared prescaler tick
//   en, mode, period   channel configuration
//   clr                write-1-to-clear of irq_flag/irq_ovf
//   timer              one-cycle expiry pulse (registered)
//   irq_flag, irq_ovf  sticky flags
//   running            channel is in RUN (keeps the prescaler going)
//   cnt                current count
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             chosen_clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic             clr,
  output logic             timer,
  output logic             irq_flag,
  output logic             irq_ovf,
  output logic             running,
  output logic [WIDTH-1:0] cnt
);

  ch_state_t state;
  logic      expire;

  // >= rather than == so a period lowered below the running count
  // expires on the next tick instead of wrapping the counter.
  assign expire  = en && (state == ST_RUN) && (period != '0) && tick && (cnt >= period);
  assign running = (state == ST_RUN);

  // NOTE: every register here is assigned with <= so all of them update
  // from the same pre-edge values; blocking assignments would let later
  // statements see half-updated state.
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      timer    <= 1'b0;
      irq_flag <= 1'b0;
      irq_ovf  <= 1'b0;
    end else begin
      timer <= expire;

      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (period != '0) begin
              state <= ST_RUN;
              cnt   <= '0;
            end
          end
          ST_RUN: begin
            if (period == '0) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (expire) begin
              cnt   <= '0;
              state <= (mode == MODE_CONT) ? ST_RUN : ST_DONE;
            end else if (tick) begin
              cnt <= cnt + WIDTH'(1);
            end
          end
          ST_DONE: cnt <= '0;
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end

      // Expiry beats a simultaneous clear; overflow is only recorded when
      // an unacknowledged flag is hit again.
      if (expire) begin
        irq_flag <= 1'b1;
        if (irq_flag && !clr) irq_ovf <= 1'b1;
      end else if (clr) begin
        irq_flag <= 1'b0;
        irq_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// N_CH independent timer channels sharing one programmable prescaler.
// Ports:
//   chosen_clk  active-high clock (selected upstream)
//   rst_n       asynchronous active-low reset
//   bus         multi_timer_if slave: configuration in, pulses/flags out
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic          chosen_clk,
  input  logic          rst_n,
  multi_timer_if.slave  bus
);

  logic [PRESC_W-1:0]    pre_cnt;
  logic                  tick;
  logic                  any_run;
  logic [N_CH-1:0]       running;
  logic [N_CH-1:0]       timer_v;
  logic [N_CH-1:0]       flag_v;
  logic [N_CH-1:0]       ovf_v;
  logic [N_CH*WIDTH-1:0] cnt_v;

  assign any_run = |running;
  assign tick    = (pre_cnt == bus.prescale);

  // The prescaler only runs while some channel is counting, so every
  // freshly started channel on an otherwise idle timer sees the same phase.
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!any_run || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESC_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .chosen_clk (chosen_clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .en         (bus.ch_en[gi]),
      .mode       (bus.ch_mode[gi]),
      .period     (bus.period[gi*WIDTH +: WIDTH]),
      .clr        (bus.irq_clr[gi]),
      .timer      (timer_v[gi]),
      .irq_flag   (flag_v[gi]),
      .irq_ovf    (ovf_v[gi]),
      .running    (running[gi]),
      .cnt        (cnt_v[gi*WIDTH +: WIDTH])
    );
  end

  assign bus.timer    = timer_v;
  assign bus.irq_flag = flag_v;
  assign bus.irq_ovf  = ovf_v;
  assign bus.cnt_dbg  = cnt_v;
  // Flags are registers, so irq is glitch-free while tracking them directly.
  assign bus.irq      = |(flag_v & bus.irq_mask);

endmodule
